// File: rtl/calc_pkg.sv
// Shared definitions for the hex keypad calculator: opcode values and
// controller state encoding. Also imported by the keypad interpreter.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_INV = 2'b11;

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        MULT    = 2'b10,
        SHOW    = 2'b11
    } calc_state_t;

    // Only ADD and MULTIPLY act; 10 and 11 are dropped by the controller.
    function automatic logic op_valid(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/calc_mult_seq.sv
// Radix-2 shift-add multiplier, LSB-first, one multiplier bit per cycle.
// Bit 0 is folded into the start cycle so the full product is ready, with
// a one-cycle done pulse, WIDTH-1 cycles after start.
module calc_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               running;

    // Load on start (consuming bit 0), then add the shifted multiplicand per set bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc     <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                mplier  <= b >> 1;
                cnt     <= CW'(1);
                running <= 1'b1;
            end else if (running) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (cnt == LAST) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/calc_controller.sv
// Keypad calculator sequencer: assembles two hex operands, runs ADD in one
// cycle or MULTIPLY on calc_mult_seq, and selects the displayed value.
// Optional build macro: CALC_OVERFLOW_EN enables the ovf flag (carry out of
// the add, or nonzero upper product half); without it ovf stays 0.
module calc_controller
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             newhex,
    input  logic [3:0]       hexcode,
    input  logic             newop,
    input  logic [1:0]       opcode,
    input  logic             eq,
    output logic [WIDTH-1:0] display,
    output logic             busy,
    output logic [1:0]       op_pend,
    output logic             ovf
);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("calc_controller: WIDTH must be a multiple of 4 and >= 8");
    end

    calc_state_t      state, state_n;
    logic [WIDTH-1:0] a, a_n;
    logic [WIDTH-1:0] b, b_n;
    logic [WIDTH-1:0] result, result_n;
    logic [1:0]       op_reg, op_n;
    logic             ovf_reg, ovf_n;

    logic               mult_start;
    logic               mult_done;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0]   sum_lo;
    logic               add_carry;
    logic               mul_hi;

    // Only the highest-priority pulse acts; an invalid operator still masks newhex.
    logic ev_eq, ev_op, ev_hex;
    assign ev_eq  = eq;
    assign ev_op  = !eq && newop && op_valid(opcode);
    assign ev_hex = !eq && !newop && newhex;

`ifdef CALC_OVERFLOW_EN
    assign {add_carry, sum_lo} = {1'b0, a} + {1'b0, b};
    assign mul_hi              = |product[2*WIDTH-1:WIDTH];
`else
    assign sum_lo    = a + b;
    assign add_carry = 1'b0;
    assign mul_hi    = 1'b0;
`endif

    calc_mult_seq #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mult_start),
        .a       (a),
        .b       (b),
        .done    (mult_done),
        .product (product)
    );

    // State and datapath registers; reset aborts everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ENTER_A;
            a       <= '0;
            b       <= '0;
            result  <= '0;
            op_reg  <= OP_ADD;
            ovf_reg <= 1'b0;
        end else begin
            state   <= state_n;
            a       <= a_n;
            b       <= b_n;
            result  <= result_n;
            op_reg  <= op_n;
            ovf_reg <= ovf_n;
        end
    end

    // Next-state and register updates for each key event per state.
    always_comb begin
        state_n    = state;
        a_n        = a;
        b_n        = b;
        result_n   = result;
        op_n       = op_reg;
        ovf_n      = ovf_reg;
        mult_start = 1'b0;
        case (state)
            ENTER_A: begin
                if (ev_op) begin
                    op_n    = opcode;
                    b_n     = '0;
                    state_n = ENTER_B;
                end else if (ev_hex) begin
                    a_n = {a[WIDTH-5:0], hexcode};
                end
            end
            ENTER_B: begin
                if (ev_eq) begin
                    if (op_reg == OP_MUL) begin
                        mult_start = 1'b1;
                        state_n    = MULT;
                    end else begin
                        result_n = sum_lo;
                        ovf_n    = add_carry;
                        state_n  = SHOW;
                    end
                end else if (ev_op) begin
                    op_n = opcode;
                end else if (ev_hex) begin
                    b_n = {b[WIDTH-5:0], hexcode};
                end
            end
            MULT: begin
                // Keys are dropped here; only the multiplier advances us.
                if (mult_done) begin
                    result_n = product[WIDTH-1:0];
                    ovf_n    = mul_hi;
                    state_n  = SHOW;
                end
            end
            SHOW: begin
                if (ev_op) begin
                    a_n     = result;
                    b_n     = '0;
                    ovf_n   = 1'b0;
                    op_n    = opcode;
                    state_n = ENTER_B;
                end else if (ev_hex) begin
                    a_n     = {{(WIDTH-4){1'b0}}, hexcode};
                    ovf_n   = 1'b0;
                    state_n = ENTER_A;
                end
            end
            default: state_n = ENTER_A;
        endcase
    end

    // Display follows the operand being edited, or the result once shown.
    always_comb begin
        case (state)
            ENTER_A: display = a;
            SHOW:    display = result;
            default: display = b;
        endcase
    end

    assign busy    = (state == MULT);
    assign op_pend = op_reg;
    assign ovf     = ovf_reg;

endmodule

// File: doc/calc_controller.md
# calc_controller

Sequencing controller for the hex keypad calculator. It consumes the one-cycle key events from the keypad interpreter: hex digits, operators and equals. It assembles two operands, runs the selected operation, and drives the value shown on the display. Addition completes in one cycle. Multiplication runs on a shared shift-add multiplier over WIDTH cycles, and the controller holds off key input while that runs.

## Interface
- WIDTH, 16: operand, result and display width in bits. Must be a multiple of 4 and at least 8.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- newhex  in  1  one-cycle pulse: a hex digit was pressed.
- hexcode  in  4  digit value; valid while newhex is high.
- newop  in  1  one-cycle pulse: an operator was pressed.
- opcode  in  2  operator: 00 = ADD, 01 = MULTIPLY, 11 = invalid; valid while newop is high.
- eq  in  1  one-cycle pulse: equals was pressed.
- display  out  WIDTH  value currently shown.
- busy  out  1  high while a multiply is in progress.
- op_pend  out  2  latched pending operator.
- ovf  out  1  overflow flag of the last result.

## Operation
- Reset: state ENTER_A; operand registers a, b and result = 0; op_pend = ADD; display = 0; busy = 0; ovf = 0.
- Input priority when several inputs are high in the same cycle: eq > newop > newhex. Only the highest-priority event acts.
- An opcode of 11 or 10 on newop is ignored: no state change and no register change.
- ENTER_A:
  - newhex: a <= {a[WIDTH-5:0], hexcode}. The top digit is discarded and a wraps silently.
  - Valid newop: latch op_pend, clear b, go to ENTER_B.
  - eq: ignored.
  - display = a.
- ENTER_B:
  - newhex: b shifts in a digit, exactly as a does in ENTER_A.
  - Valid newop: replaces op_pend and stays in ENTER_B; b is kept.
  - eq with ADD: result <= a + b, truncated to WIDTH bits; go to SHOW.
  - eq with MULTIPLY: start the multiplier with a and b; go to MULT.
  - display = b.
- MULT:
  - busy = 1.
  - newhex, newop and eq are dropped, not queued.
  - When the multiplier signals done, result <= the low WIDTH bits of the product; go to SHOW.
  - display holds b.
- SHOW:
  - display = result.
  - newhex: clear ovf, a <= {0, hexcode}, go to ENTER_A.
  - Valid newop (chaining): a <= result, clear b and ovf, latch op_pend, go to ENTER_B.
  - eq: ignored.
- Multiplier: radix-2 shift-add. It uses a 2·WIDTH-bit accumulator and consumes one multiplier bit per cycle, LSB first.

## Timing
- ADD: eq at edge t. From t+1: state SHOW, display = result, ovf valid.
- MULTIPLY: eq at edge t. busy is high from t+1 through t+WIDTH. From t+WIDTH+1: SHOW, display = result, busy = 0.
- Digit entry: display updates on the cycle after newhex.
- Reset asserted mid-multiply: the multiplier aborts immediately and all outputs return to their reset values asynchronously. No result is written.
- Key pulses arriving while busy = 1 have no effect, including eq.

## Configuration
- CALC_OVERFLOW_EN defined: ovf is set in the SHOW-entry cycle for either of two cases:
  - ADD: the carry out of bit WIDTH-1 is set.
  - MULTIPLY: any bit of product[2·WIDTH-1:WIDTH] is nonzero.
  - ovf holds until SHOW is left.
- CALC_OVERFLOW_EN undefined:
  - ovf is tied to 0.
  - No carry or upper-product detection logic is built.
  - Results still wrap modulo 2^WIDTH.

## Structure
- Shared package calc_pkg holds:
  - opcode constants OP_ADD = 2'b00, OP_MUL = 2'b01, OP_INV = 2'b11;
  - the state enum ENTER_A, ENTER_B, MULT, SHOW.
- The keypad interpreter also imports calc_pkg for the opcode values.
- One sub-module, calc_mult_seq:
  - inputs: start, a, b;
  - outputs: done (one-cycle pulse) and product (2·WIDTH bits);
  - parameterised by WIDTH.

## Test plan
- Digits 1,2, op ADD, digits 3,4, eq → display 0x0046 one cycle after eq; busy never high.
- Digits 1,2, op MULTIPLY, digits 3,4, eq → busy high exactly 16 cycles, then display 0x03A8; a newhex 7 pulsed mid-busy has no effect.
- Digits F,F,F,F, op ADD, digit 1, eq → display 0x0000; ovf = 1 with CALC_OVERFLOW_EN, 0 without.
- Digits 1,2,3,4,5 → display 0x2345; opcode 11 pulse then stays ENTER_A with op_pend unchanged.
- 2 + 3 eq (display 0x0005), then op MULTIPLY, digit 4, eq → display 0x0014 after 16 busy cycles.
- Start 0xFF × 0xFF, assert rst at busy cycle 5 → display 0, busy 0, state ENTER_A immediately; a subsequent 1 + 1 eq gives 0x0002.
